// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder self-check stage.
//   state_t        : top-level run state
//   DEF_*          : default block parameters
//   calc_expected  : reference sum, one bit wider than the operands
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_NUM_VECTORS = 256;
    localparam int DEF_COUNT_W     = 9;

    // Works on 32-bit containers so any WIDTH up to 32 can share it; the
    // caller zero-extends operands in and truncates to WIDTH+1 bits out.
    function automatic logic [32:0] calc_expected(input logic [31:0] a,
                                                  input logic [31:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_sum_checker_if.sv
// Tuple handshake between the adder under test and the checker.
//   valid/ready : transfer when both high on a rising clock edge
//   a, b        : operands (WIDTH bits)
//   sum         : adder result under test (WIDTH+1 bits)
interface adder_sum_checker_if #(
    parameter int WIDTH = 4
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;

    modport master (output valid, a, b, sum, input ready);
    modport slave  (input valid, a, b, sum, output ready);
endinterface

// File: rtl/adder_chk_capture.sv
// Compare register and first-mismatch capture.
//   clk, rst_n        : clock, async active-low reset
//   i_clear           : start of a new run; drops pending compare and capture
//   i_load            : a tuple transfers this cycle
//   i_a, i_b, i_sum   : transferred tuple
//   o_retire          : registered tuple is compared this cycle
//   o_mismatch        : registered tuple failed (qualified by o_retire)
//   o_first_bad_*     : captured first failing tuple and its valid flag
module adder_chk_capture
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH:0]   i_sum,
    output logic             o_retire,
    output logic             o_mismatch,
    output logic             o_first_bad_valid,
    output logic [WIDTH-1:0] o_first_bad_a,
    output logic [WIDTH-1:0] o_first_bad_b,
    output logic [WIDTH:0]   o_first_bad_sum
);

    logic             r_vld;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_sum;
    logic             r_fb_vld;
    logic [WIDTH-1:0] r_fb_a;
    logic [WIDTH-1:0] r_fb_b;
    logic [WIDTH:0]   r_fb_sum;

    logic [WIDTH:0]   w_exp;
    logic             w_mis;

    assign w_exp = (WIDTH+1)'(calc_expected(32'(r_a), 32'(r_b)));
    assign w_mis = r_vld && (r_sum != w_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_fb_vld <= 1'b0;
            r_fb_a   <= '0;
            r_fb_b   <= '0;
            r_fb_sum <= '0;
        end else if (i_clear) begin
            r_vld    <= 1'b0;
            r_fb_vld <= 1'b0;
            r_fb_a   <= '0;
            r_fb_b   <= '0;
            r_fb_sum <= '0;
        end else begin
            // Stage valid follows the handshake every cycle so a retired
            // tuple is never compared twice.
            r_vld <= i_load;
            if (i_load) begin
                r_a   <= i_a;
                r_b   <= i_b;
                r_sum <= i_sum;
            end
            if (w_mis && !r_fb_vld) begin
                r_fb_vld <= 1'b1;
                r_fb_a   <= r_a;
                r_fb_b   <= r_b;
                r_fb_sum <= r_sum;
            end
        end
    end

    assign o_retire          = r_vld;
    assign o_mismatch        = w_mis;
    assign o_first_bad_valid = r_fb_vld;
    assign o_first_bad_a     = r_fb_a;
    assign o_first_bad_b     = r_fb_b;
    assign o_first_bad_sum   = r_fb_sum;

endmodule

// File: rtl/adder_sum_checker.sv
// On-chip self-check for the adder datapath: accepts NUM_VECTORS tuples,
// recomputes each sum, counts checks and mismatches, captures the first bad
// tuple and reports pass/fail.
//   clk, rst_n          : clock, async active-low reset
//   i_start             : one-cycle pulse, starts a run from IDLE or DONE
//   s_in                : tuple handshake (slave side)
//   o_busy / o_done     : run in progress / run finished (held until start)
//   o_pass              : no mismatches, valid while o_done
//   o_checked_cnt       : tuples compared this run
//   o_mismatch_cnt      : failing tuples this run
//   o_first_bad_*       : first failing tuple and its valid flag
module adder_sum_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_VECTORS = DEF_NUM_VECTORS,
    parameter int COUNT_W     = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    adder_sum_checker_if.slave s_in,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [COUNT_W-1:0] o_checked_cnt,
    output logic [COUNT_W-1:0] o_mismatch_cnt,
    output logic               o_first_bad_valid,
    output logic [WIDTH-1:0]   o_first_bad_a,
    output logic [WIDTH-1:0]   o_first_bad_b,
    output logic [WIDTH:0]     o_first_bad_sum
);

    localparam logic [COUNT_W-1:0] LP_NUM  = COUNT_W'(NUM_VECTORS);
    localparam logic [COUNT_W-1:0] LP_LAST = COUNT_W'(NUM_VECTORS - 1);
    localparam logic [COUNT_W-1:0] LP_ONE  = COUNT_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [COUNT_W-1:0] r_acc_cnt;
    logic [COUNT_W-1:0] r_chk_cnt;
    logic [COUNT_W-1:0] r_mis_cnt;

    logic w_start_go;
    logic w_ready;
    logic w_xfer;
    logic w_retire;
    logic w_mismatch;
    logic w_last;

    // start is honoured only outside RUN.
    assign w_start_go = i_start && (r_state != RUN);
    // Accept counter, not the compare counter, gates ready so that no
    // extra tuple slips in while the final compare is still in flight.
    assign w_ready    = (r_state == RUN) && (r_acc_cnt != LP_NUM);
    assign w_xfer     = s_in.valid && w_ready;
    assign w_last     = w_retire && (r_chk_cnt == LP_LAST);
    assign s_in.ready = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_go) w_next = RUN;
            RUN:     if (w_last)     w_next = DONE;
            DONE:    if (w_start_go) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
            r_chk_cnt <= '0;
            r_mis_cnt <= '0;
        end else if (w_start_go) begin
            r_acc_cnt <= '0;
            r_chk_cnt <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_xfer)                  r_acc_cnt <= r_acc_cnt + LP_ONE;
            if (w_retire)                r_chk_cnt <= r_chk_cnt + LP_ONE;
            if (w_retire && w_mismatch)  r_mis_cnt <= r_mis_cnt + LP_ONE;
        end
    end

    adder_chk_capture #(.WIDTH(WIDTH)) u_capture (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_clear           (w_start_go),
        .i_load            (w_xfer),
        .i_a               (s_in.a),
        .i_b               (s_in.b),
        .i_sum             (s_in.sum),
        .o_retire          (w_retire),
        .o_mismatch        (w_mismatch),
        .o_first_bad_valid (o_first_bad_valid),
        .o_first_bad_a     (o_first_bad_a),
        .o_first_bad_b     (o_first_bad_b),
        .o_first_bad_sum   (o_first_bad_sum)
    );

    assign o_busy         = (r_state == RUN);
    assign o_done         = (r_state == DONE);
    assign o_pass         = (r_state == DONE) && (r_mis_cnt == '0);
    assign o_checked_cnt  = r_chk_cnt;
    assign o_mismatch_cnt = r_mis_cnt;

endmodule

// File: tb/tb_adder_sum_checker.sv
module tb_adder_sum_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, pass, fb_valid;
    logic [8:0] checked_cnt, mismatch_cnt;
    logic [3:0] fb_a, fb_b;
    logic [4:0] fb_sum;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder_sum_checker_if #(.WIDTH(4)) bif ();

    adder_sum_checker #(.WIDTH(4), .NUM_VECTORS(256), .COUNT_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .s_in(bif),
        .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_checked_cnt(checked_cnt), .o_mismatch_cnt(mismatch_cnt),
        .o_first_bad_valid(fb_valid), .o_first_bad_a(fb_a),
        .o_first_bad_b(fb_b), .o_first_bad_sum(fb_sum)
    );

    // Reference model: a run is "active" until 256 tuples have been checked;
    // each accepted tuple is judged one edge after it is accepted.
    typedef struct packed {
        logic        run;
        logic        done;
        logic [15:0] acc;
        logic [15:0] chk;
        logic [15:0] mis;
        logic        pv;
        logic [3:0]  pa, pb;
        logic [4:0]  ps;
        logic        fv;
        logic [3:0]  fa, fb;
        logic [4:0]  fs;
        logic        took;
    } model_t;

    model_t m = '0;

    function automatic model_t step(model_t s, logic st, logic v,
                                    logic [3:0] a, logic [3:0] b, logic [4:0] sm);
        model_t n = s;
        logic [4:0] exp_sum;
        n.took = s.run && v && (s.acc < 256);
        if (s.pv) begin
            exp_sum = {1'b0, s.pa} + {1'b0, s.pb};
            n.chk = s.chk + 1;
            if (s.ps !== exp_sum) begin
                n.mis = s.mis + 1;
                if (!s.fv) begin
                    n.fv = 1'b1; n.fa = s.pa; n.fb = s.pb; n.fs = s.ps;
                end
            end
            if (n.chk == 256) begin n.run = 1'b0; n.done = 1'b1; end
        end
        n.pv = n.took;
        if (n.took) begin
            n.pa = a; n.pb = b; n.ps = sm; n.acc = s.acc + 1;
        end
        if (st && !s.run) begin
            n = '0;
            n.run = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m <= '0;
        else        m <= step(m, start, bif.valid, bif.a, bif.b, bif.sum);

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("ready", int'(bif.ready), int'(m.run && m.acc < 256));
        chk("busy", int'(busy), int'(m.run));
        chk("done", int'(done), int'(m.done));
        chk("pass", int'(pass), int'(m.done && m.mis == 0));
        chk("checked_cnt", int'(checked_cnt), int'(m.chk));
        chk("mismatch_cnt", int'(mismatch_cnt), int'(m.mis));
        chk("fb_valid", int'(fb_valid), int'(m.fv));
        chk("fb_a", int'(fb_a), int'(m.fa));
        chk("fb_b", int'(fb_b), int'(m.fb));
        chk("fb_sum", int'(fb_sum), int'(m.fs));
    end

    // Handshake transfers seen on the bus, independent of the model.
    int acc_seen = 0;
    always @(negedge clk) if (rst_n && bif.valid && bif.ready) acc_seen++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
        int n = 0;
        bif.valid = 1'b1; bif.a = a; bif.b = b; bif.sum = s;
        do begin tick(); n++; end while (!m.took && n < 50);
        if (!m.took) chk("send_timeout", 0, 1);
        bif.valid = 1'b0;
    endtask

    task automatic pulse_start(input logic with_valid);
        start = 1'b1;
        bif.valid = with_valid; bif.a = 4'd0; bif.b = 4'd0; bif.sum = 5'd0;
        tick();
        start = 1'b0;
        bif.valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!m.done && n < 40) begin tick(); n++; end
        if (!m.done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        logic [7:0] k;
        logic [4:0] s;
        bif.valid = 1'b0; bif.a = '0; bif.b = '0; bif.sum = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_checked", int'(checked_cnt), 0);
        chk("rst_ready", int'(bif.ready), 0);
        tick();

        // Run 1: clean exhaustive sweep; start coincides with in_valid.
        pulse_start(1'b1);
        for (int i = 0; i < 256; i++) begin
            k = 8'(i);
            send(k[7:4], k[3:0], {1'b0, k[7:4]} + {1'b0, k[3:0]});
        end
        @(negedge clk);
        chk("done_not_yet", int'(done), 0);
        @(negedge clk);
        chk("clean_done", int'(done), 1);
        chk("clean_checked", int'(checked_cnt), 256);
        chk("clean_mis", int'(mismatch_cnt), 0);
        chk("clean_pass", int'(pass), 1);
        chk("clean_fbv", int'(fb_valid), 0);
        tick();

        // Run 2: restart from DONE, two injected faults, start ignored in RUN.
        pulse_start(1'b0);
        @(negedge clk);
        chk("restart_busy", int'(busy), 1);
        chk("restart_checked", int'(checked_cnt), 0);
        tick();
        for (int i = 0; i < 256; i++) begin
            k = 8'(i);
            s = {1'b0, k[7:4]} + {1'b0, k[3:0]};
            if (k == 8'h35) s = 5'b01001;
            if (k == 8'hFF) s = 5'b01110;
            send(k[7:4], k[3:0], s);
            if (i == 50) pulse_start(1'b0);
        end
        wait_done();
        chk("fault_mis", int'(mismatch_cnt), 2);
        chk("fault_pass", int'(pass), 0);
        chk("fault_fb_a", int'(fb_a), 3);
        chk("fault_fb_b", int'(fb_b), 5);
        chk("fault_fb_sum", int'(fb_sum), 9);
        tick();

        // Run 3: carry-out cases, gapped valid, then overrun.
        pulse_start(1'b0);
        base = acc_seen;
        send(4'd15, 4'd1, 5'b00000);
        for (int i = 1; i < 256; i++) begin
            k = 8'(i);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            send(k[7:4], k[3:0], {1'b0, k[7:4]} + {1'b0, k[3:0]});
        end
        bif.valid = 1'b1; bif.a = 4'd2; bif.b = 4'd2; bif.sum = 5'd4;
        repeat (10) tick();
        @(negedge clk);
        chk("overrun_accepts", acc_seen - base, 256);
        chk("overrun_ready", int'(bif.ready), 0);
        chk("overrun_done", int'(done), 1);
        chk("carry_mis", int'(mismatch_cnt), 1);
        chk("carry_fb_a", int'(fb_a), 15);
        chk("carry_fb_b", int'(fb_b), 1);
        chk("carry_fb_sum", int'(fb_sum), 0);
        bif.valid = 1'b0;
        tick();

        // Run 4: abort by reset after 100 vectors with 3 mismatches.
        pulse_start(1'b0);
        for (int i = 0; i < 100; i++) begin
            k = 8'(i);
            s = {1'b0, k[7:4]} + {1'b0, k[3:0]};
            if (i == 10 || i == 20 || i == 30) s = s ^ 5'd1;
            send(k[7:4], k[3:0], s);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_checked", int'(checked_cnt), 0);
        chk("abort_mis", int'(mismatch_cnt), 0);
        chk("abort_fbv", int'(fb_valid), 0);
        chk("abort_ready", int'(bif.ready), 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++) send(4'(i), 4'd1, 5'(i + 1));
        repeat (2) tick();
        @(negedge clk);
        chk("fresh_checked", int'(checked_cnt), 5);
        chk("fresh_mis", int'(mismatch_cnt), 0);
        chk("fresh_busy", int'(busy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/adder_sum_checker.md
# adder_sum_checker

Downstream self-check stage for the 4-bit adder datapath. It accepts one operand/result tuple per handshake, recomputes the expected sum internally, and counts checked vectors and mismatches. It captures the first failing tuple and reports pass/fail after a programmed number of vectors. It brings the testbench-style expected-vs-actual comparison into synthesizable hardware for on-chip BIST.

## Interface
- WIDTH, 4: operand width; sum width is WIDTH+1.
- NUM_VECTORS, 256: vectors per run (exhaustive sweep for WIDTH=4).
- COUNT_W, 9: counter width; must hold NUM_VECTORS.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  input  1  upstream tuple valid.
- in_ready  output  1  checker accepts a tuple this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sum  input  WIDTH+1  adder result under test.
- busy  output  1  high in RUN.
- done  output  1  high in DONE, held until next start.
- pass  output  1  valid when done=1; 1 iff mismatch_cnt==0.
- checked_cnt  output  COUNT_W  tuples compared this run.
- mismatch_cnt  output  COUNT_W  failing tuples this run.
- first_bad_valid  output  1  a mismatch has been captured.
- first_bad_a / first_bad_b  output  WIDTH  operands of the first mismatch.
- first_bad_sum  output  WIDTH+1  DUT sum of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is implementation-free.
- IDLE: in_ready=0. On start, go to RUN and clear all counters and capture registers.
- RUN: in_ready=1 except in the cycle the final tuple's compare retires (see Timing). A transfer occurs when in_valid && in_ready.
- Compare stage: the transferred tuple is registered. expected = zero-extended a + zero-extended b, WIDTH+1 bits, no truncation. mismatch = (sum_r != expected); any X/Z in sum counts as mismatch (case-inequality semantics in model).
- On compare retire:
  - checked_cnt += 1.
  - If mismatch: mismatch_cnt += 1, and if first_bad_valid==0, capture a/b/sum and set first_bad_valid.
- When checked_cnt reaches NUM_VECTORS, go to DONE.
- DONE: in_ready=0, done=1, pass = (mismatch_cnt==0). Counters and capture registers hold.
- start in DONE restarts the run (same as from IDLE). start in RUN is ignored.
- Counters never exceed NUM_VECTORS, so no wrap-around.
- Reset value of every output is 0. Reset mid-run aborts immediately to IDLE with everything cleared.

## Timing
- Transfer in cycle N → compare register loaded at edge N → counters and capture update at edge N+1. Result latency is 1 cycle.
- Back-to-back transfers are supported at 1 tuple/cycle with no bubbles.
- Accepted tuple count is bounded to exactly NUM_VECTORS:
  - in_ready drops combinationally once accepted-count == NUM_VECTORS. A separate accept counter or pending flag tracks this.
  - Extra in_valid is left pending upstream and is not consumed.
- DONE is entered on the edge where the last compare retires. done is visible the following cycle together with the final counts.
- start asserted together with in_valid in IDLE: start takes effect, and no transfer occurs that cycle because in_ready=0.
- in_valid may drop between tuples. The checker never requires in_valid to be held.

## Structure
- Shared package adder_chk_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default WIDTH, NUM_VECTORS, COUNT_W constants;
  - function calc_expected(a, b).
- One natural sub-module, adder_chk_capture: compare register plus first-mismatch capture. The top keeps the FSM, counters and handshake.

## Test plan
- Clean exhaustive sweep: start, feed all 256 (a,b) with correct sum back-to-back → done after 256 transfers + 1 cycle, checked_cnt=256, mismatch_cnt=0, pass=1, first_bad_valid=0.
- Injected faults: corrupt sum for a=4'b0011,b=4'b0101 (send 5'b01001) and for a=15,b=15 (send 5'b01110) → mismatch_cnt=2, pass=0, first_bad = {0011, 0101, 01001}.
- Carry-out check: a=15,b=1 with sum=5'b10000 → OK. With sum=5'b00000 → mismatch. Confirms width is not truncated.
- Gapped valid plus overrun: random in_valid gaps, then in_valid held high past vector 256 → exactly 256 accepted, in_ready=0 after the 256th, done asserted.
- Reset mid-run: rst_n low after 100 vectors with 3 mismatches → all outputs 0 asynchronously. A subsequent start gives a fresh run with counts from 0.
- Restart from DONE: start pulse in DONE → counters cleared, busy=1 next cycle. start pulsed during RUN → no effect on counts.
